// File: rtl/chart_sample_buffer_if.sv
// Sample stream from the acquisition/FFT front end into the chart sample buffer.
// Latency: none; plain wires carrying one signed sample per accepted beat.
// Backpressure: a beat transfers when s_valid && s_ready at clk rise.
interface chart_sample_buffer_if #(
   parameter int DW = 16
);
   logic signed [DW-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/chart_sample_buffer.sv
// Double-banked 2^AW x DW frame writer feeding the chart renderer, with optional rising-edge trigger.
// Latency: rd_data is registered (1 cycle after rd_addr); bank swap 1 cycle after the last sample if the renderer is idle.
// Backpressure: s_ready drops only in FULL while the swap waits on the renderer. Macro CHART_SAMPLE_BUFFER_DECIM_EN adds decim[3:0].
module chart_sample_buffer #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   chart_sample_buffer_if.slave smp,
   input  logic                 arm,
   input  logic                 cont,
   input  logic                 trig_en,
   input  logic signed [DW-1:0] trig_level,
   input  logic [11:0]          rd_addr,
   output logic signed [DW-1:0] rd_data,
   input  logic                 rd_start,
   input  logic                 rd_done,
`ifdef CHART_SAMPLE_BUFFER_DECIM_EN
   input  logic [3:0]           decim,
`endif
   output logic                 frame_ready,
   output logic                 busy
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, TRIG, FILL, FULL} state_t;

   state_t               state, state_nxt;
   logic                 wsel;
   logic [AW-1:0]        wptr;
   logic signed [DW-1:0] prev;
   logic                 prev_valid;
   logic                 reader_busy;

   logic                 accept;
   logic                 take;
   logic                 start;
   logic                 trig_hit;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic                 swap;

   logic [DW-1:0]        mem [2*DEPTH];

   // Upper renderer address bits address a larger display buffer and are not used here.
   logic                 rd_addr_unused;
   assign rd_addr_unused = ^rd_addr[11:AW];

   assign smp.s_ready = (state != FULL);
   assign busy        = (state != IDLE);
   assign accept      = smp.s_valid && smp.s_ready;

`ifdef CHART_SAMPLE_BUFFER_DECIM_EN
   logic [3:0] dcnt;

   // Decimation phase: phase 0 samples are used; the triggering sample is phase 0 of its cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         dcnt <= '0;
      else if (start)
         dcnt <= '0;
      else if (accept && (state == TRIG || state == FILL))
         dcnt <= (dcnt == decim) ? 4'd0 : dcnt + 4'd1;
   end

   assign take = accept && (dcnt == 4'd0);
`else
   assign take = accept;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state, trigger detection, write strobe and bank swap decision.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      trig_hit  = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = wptr;
      swap      = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               start     = 1'b1;
               state_nxt = trig_en ? TRIG : FILL;
            end
         end
         TRIG: begin
            if (take && prev_valid && (prev < trig_level) && (smp.s_data >= trig_level)) begin
               trig_hit  = 1'b1;
               wr_en     = 1'b1;
               wr_addr   = '0;
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (take) begin
               wr_en = 1'b1;
               if (wptr == {AW{1'b1}})
                  state_nxt = FULL;
            end
         end
         FULL: begin
            // Registered reader_busy blocks the swap even in the rd_done cycle.
            if (!reader_busy) begin
               swap = 1'b1;
               if (cont) begin
                  start     = 1'b1;
                  state_nxt = trig_en ? TRIG : FILL;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write pointer and trigger history; wptr wraps to 0 on the last write of a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
      end else begin
         if (start)
            wptr <= '0;
         else if (trig_hit)
            wptr <= AW'(1);
         else if (wr_en)
            wptr <= wptr + AW'(1);

         if (start)
            prev_valid <= 1'b0;
         else if (state == TRIG && take)
            prev_valid <= 1'b1;

         if (state == TRIG && take)
            prev <= smp.s_data;
      end
   end

   // Bank select, frame status and renderer activity tracking; set wins on coincidence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wsel        <= 1'b0;
         frame_ready <= 1'b0;
         reader_busy <= 1'b0;
      end else begin
         if (swap)
            wsel <= ~wsel;

         if (swap)
            frame_ready <= 1'b1;
         else if (rd_start)
            frame_ready <= 1'b0;

         if (rd_start)
            reader_busy <= 1'b1;
         else if (rd_done)
            reader_busy <= 1'b0;
      end
   end

   // Sample storage write into the current write bank.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[{wsel, wr_addr}] <= smp.s_data;
   end

   // Registered renderer read from the read bank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rd_data <= '0;
      else
         rd_data <= mem[{~wsel, rd_addr[AW-1:0]}];
   end

endmodule

// File: tb/tb_chart_sample_buffer.sv
// Directed bench for chart_sample_buffer: free-run fill, trigger, renderer-held swap, continuous frames, reset.
// Latency: samples outputs on the falling edge, half a cycle after the registering edge.
// Backpressure: the sample driver holds each beat until s_ready is seen high.
module tb_chart_sample_buffer;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                arm, cont, trig_en, rd_start, rd_done;
   logic signed [15:0]  trig_level;
   logic [11:0]         rd_addr;
   logic signed [15:0]  rd_data;
   logic                frame_ready, busy;
`ifdef CHART_SAMPLE_BUFFER_DECIM_EN
   logic [3:0]          decim;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int stalls = 0;

   chart_sample_buffer_if #(.DW(16)) smp ();

   chart_sample_buffer #(.AW(10), .DW(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .smp        (smp),
      .arm        (arm),
      .cont       (cont),
      .trig_en    (trig_en),
      .trig_level (trig_level),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_start   (rd_start),
      .rd_done    (rd_done),
`ifdef CHART_SAMPLE_BUFFER_DECIM_EN
      .decim      (decim),
`endif
      .frame_ready(frame_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one sample and hold it until the buffer accepts it.
   task automatic send(input int v);
      int g;
      g = 0;
      smp.s_data  = 16'(v);
      smp.s_valid = 1'b1;
      while (smp.s_ready !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
         stalls++;
      end
      if (g >= 200) check("send_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic stream(input int base, input int step, input int n);
      for (int i = 0; i < n; i++) send(base + step * i);
      smp.s_valid = 1'b0;
   endtask

   task automatic rd(input int a, output logic signed [15:0] d);
      rd_addr = 12'(a);
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic verify_bank(input string tag, input int base, input int step);
      logic signed [15:0] d;
      int bad;
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
         rd(k, d);
         if (d !== 16'(base + step * k)) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic pulse_start();
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
   endtask

   task automatic pulse_done();
      rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic signed [15:0] d;
      logic exp_wsel;
      reset_n = 1'b0; arm = 1'b0; cont = 1'b0; trig_en = 1'b0;
      rd_start = 1'b0; rd_done = 1'b0; trig_level = '0; rd_addr = '0;
      smp.s_data = '0; smp.s_valid = 1'b0;
`ifdef CHART_SAMPLE_BUFFER_DECIM_EN
      decim = 4'd0;
`endif
      repeat (2) tick();
      check("rst_s_ready", smp.s_ready, 1);
      check("rst_frame_ready", frame_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_wsel", dut.wsel, 0);
      reset_n = 1'b1;
      tick();

      // Free-run capture of 0..1023.
      pulse_arm();
      check("s1_busy", busy, 1);
      stalls = 0;
      stream(0, 1, 1024);
      check("s1_full_s_ready", smp.s_ready, 0);
      check("s1_full_frame_ready", frame_ready, 0);
      check("s1_stalls", stalls, 0);
      tick();
      check("s1_swap_frame_ready", frame_ready, 1);
      check("s1_swap_wsel", dut.wsel, 1);
      check("s1_idle_s_ready", smp.s_ready, 1);
      check("s1_idle_busy", busy, 0);
      rd(5, d);
      check("s1_rd5", d, 5);
      verify_bank("s1_bank", 0, 1);

      // Triggered capture on a ramp crossing 100.
      trig_en = 1'b1;
      trig_level = 16'sd100;
      pulse_arm();
      send(-50); send(0); send(50); send(99);
      check("s2a_pre_state", dut.state, 1);
      stream(100, 1, 1024);
      tick();
      check("s2a_wsel", dut.wsel, 0);
      rd(0, d);    check("s2a_addr0", d, 100);
      rd(1, d);    check("s2a_addr1", d, 101);
      rd(1023, d); check("s2a_addr1023", d, 1123);

      // Stream starting above the level: no trigger until a value below precedes one at/above.
      pulse_arm();
      send(200); send(300); send(250); send(150);
      check("s2b_no_trig_state", dut.state, 1);
      check("s2b_no_trig_wptr", dut.wptr, 0);
      send(50);
      check("s2b_below_state", dut.state, 1);
      stream(120, 1, 1024);
      tick();
      check("s2b_wsel", dut.wsel, 1);
      rd(0, d);    check("s2b_addr0", d, 120);
      rd(1, d);    check("s2b_addr1", d, 121);
      rd(1023, d); check("s2b_addr1023", d, 1143);

      // Renderer busy across the end of a fill holds the swap.
      trig_en = 1'b0;
      pulse_start();
      check("s3_fr_cleared", frame_ready, 0);
      pulse_arm();
      stream(2000, 1, 1024);
      repeat (4) tick();
      check("s3_hold_s_ready", smp.s_ready, 0);
      check("s3_hold_busy", busy, 1);
      check("s3_hold_wsel", dut.wsel, 1);
      check("s3_hold_frame_ready", frame_ready, 0);
      rd(0, d);
      check("s3_hold_read_bank", d, 120);
      pulse_done();
      check("s3_done_cycle_wsel", dut.wsel, 1);
      check("s3_done_cycle_s_ready", smp.s_ready, 0);
      tick();
      check("s3_swap_wsel", dut.wsel, 0);
      check("s3_swap_frame_ready", frame_ready, 1);
      verify_bank("s3_bank", 2000, 1);

      // Continuous mode: three back-to-back frames.
      cont = 1'b1;
      exp_wsel = 1'b0;
      pulse_arm();
      for (int f = 0; f < 3; f++) begin
         stream(-30000 + f * 10000, 1, 1024);
         tick();
         exp_wsel = ~exp_wsel;
         check($sformatf("s4_f%0d_wsel", f), dut.wsel, exp_wsel);
         check($sformatf("s4_f%0d_frame_ready", f), frame_ready, 1);
         check($sformatf("s4_f%0d_rearmed", f), busy, 1);
         pulse_start();
         verify_bank($sformatf("s4_f%0d_bank", f), -30000 + f * 10000, 1);
         pulse_done();
      end

      // Reset in the middle of a fill.
      stream(5, 1, 500);
      check("s5_wptr_pre", dut.wptr, 500);
      reset_n = 1'b0;
      #1;
      check("s5_rst_frame_ready", frame_ready, 0);
      check("s5_rst_busy", busy, 0);
      check("s5_rst_wsel", dut.wsel, 0);
      check("s5_rst_s_ready", smp.s_ready, 1);
      tick();
      reset_n = 1'b1;
      cont = 1'b0;
      tick();
      pulse_arm();
      stream(-1500, 3, 1024);
      tick();
      check("s5_wsel", dut.wsel, 1);
      rd(0, d);    check("s5_addr0", d, -1500);
      rd(500, d);  check("s5_addr500", d, 0);
      rd(1023, d); check("s5_addr1023", d, 1569);

`ifdef CHART_SAMPLE_BUFFER_DECIM_EN
      // Decimation by 4, then decimation disabled.
      decim = 4'd3;
      pulse_arm();
      stream(0, 1, 4093);
      tick();
      check("s6_decim3_wsel", dut.wsel, 0);
      verify_bank("s6_decim3_bank", 0, 4);
      decim = 4'd0;
      pulse_arm();
      stream(0, 1, 1024);
      tick();
      check("s6_decim0_wsel", dut.wsel, 1);
      verify_bank("s6_decim0_bank", 0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
